// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath-select encodings for the multicycle control unit
package mc_ctrl_pkg;
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_ILLEGAL   = 4'd12;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUB_REG   = 2'b00;
  localparam logic [1:0] ALUB_FOUR  = 2'b01;
  localparam logic [1:0] ALUB_IMM   = 2'b10;
  localparam logic [1:0] ALUB_IMMSH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle MIPS control FSM with memory wait states, illegal-opcode trap and retire counter
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit ADDI_EN     = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op_code,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retire_count,
  output logic [3:0]       state
);
  logic       ready;
  logic [3:0] next;
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;
  always_ff @(posedge clk) begin
    state        <= reset ? S_FETCH : next;
    retire_count <= reset ? '0 : retire_count + CNT_W'(instr_done);
  end
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:     next = ready ? S_DECODE : S_FETCH;
      S_DECODE:    next = (op_code == OP_LW || op_code == OP_SW) ? S_MEM_ADDR :
                          op_code == OP_RTYPE                    ? S_R_EXEC :
                          op_code == OP_BEQ                      ? S_BRANCH :
                          op_code == OP_J                        ? S_JUMP :
                          (ADDI_EN && op_code == OP_ADDI)        ? S_ADDI_EXEC : S_ILLEGAL;
      S_MEM_ADDR:  next = op_code == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next = ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next = ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    next = S_R_WB;
      S_ADDI_EXEC: next = S_ADDI_WB;
      default:     next = S_FETCH;
    endcase
  end
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = ready;
        pc_write  = ready;
      end
      S_DECODE:    alu_src_b = ALUB_IMMSH;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL:   illegal_op = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: doc/mc_ctrl_unit.md
Name: mc_ctrl_unit

Overview:
- Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks per instruction.
- Supersedes the single-cycle opcode decoder.
- Adds memory wait-state handshake, illegal-opcode trap, configurable addi support and a retired-instruction counter.
- Drives the multicycle datapath: PC, IR, register file, ALU muxes and memory.

Parameters:
MEM_WAIT_EN, 1, 1: honour mem_ready; 0: mem_ready ignored, treated as 1
ADDI_EN, 1, 1: addi (6'b001000) decoded; 0: addi treated as illegal
CNT_W, 16, width of retire_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op_code  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
iord  out  1  0 = PC addresses memory, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  writeback source is MDR
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
illegal_op  out  1  one-cycle pulse on undefined opcode
instr_done  out  1  one-cycle pulse on instruction retire
retire_count  out  CNT_W  retired instructions, wraps
state  out  4  current state, for debug

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high: on a clk edge with reset=1, state <= FETCH and retire_count <= 0. This overrides any in-flight access.
- Output decode:
  - Outputs are decoded combinationally from state, plus mem_ready where noted.
  - Any signal not listed for a state is 0.
  - After reset, outputs read as FETCH with mem_ready=0: mem_read=1, alu_src_b=01, all others 0.
- FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Hold while mem_ready=0; then -> DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by op_code:
  - 100011 or 101011 -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC if ADDI_EN
  - anything else -> ILLEGAL
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ(3): mem_read=1, iord=1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. -> FETCH.
- MEM_WRITE(5): mem_write=1, iord=1. Hold until mem_ready. instr_done=mem_ready; -> FETCH on mem_ready.
- R_EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
- R_WB(7): reg_write=1, reg_dst=1, instr_done=1. -> FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. -> FETCH.
- JUMP(9): pc_write=1, pc_source=10, instr_done=1. -> FETCH.
- ADDI_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00. -> ADDI_WB.
- ADDI_WB(11): reg_write=1, reg_dst=0, instr_done=1. -> FETCH.
- ILLEGAL(12): illegal_op=1 for one cycle. No register or memory side effect; instr_done=0. -> FETCH; PC was already advanced in FETCH.
- States 13-15: all outputs 0; -> FETCH next cycle.
- Latency with zero waits (clocks, FETCH to last state inclusive): lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 3. Each wait cycle adds 1.
- Memory requests: mem_read and mem_write are never both 1. A request stays asserted, with stable iord, until the cycle in which mem_ready=1.
- retire_count increments by 1 in any cycle with instr_done=1 and wraps from 2^CNT_W-1 to 0. When reset and instr_done coincide, reset wins.
- op_code is sampled only in DECODE and MEM_ADDR.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings (4-bit localparams S_FETCH .. S_ILLEGAL)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOP_ADD/SUB/FUNCT, ALUB_REG/FOUR/IMM/IMMSH, PCSRC_ALU/ALUOUT/JUMP
- No sub-module needed; single FSM with a next-state block, an output decode block and the counter.

Test Plan:
- Reset, then lw (100011) with mem_ready=1 always -> states 0,1,2,3,4; reg_write=mem_to_reg=1 in state 4; instr_done once; retire_count=1.
- sw (101011), mem_ready low for 2 cycles in MEM_WRITE -> mem_write=1, iord=1 for 3 cycles; instr_done only on the mem_ready cycle; total 6 clocks.
- R-type, then beq, then j, zero waits -> alu_op 10/01/00 as specified; pc_write_cond=1, pc_source=01 in BRANCH; pc_write=1, pc_source=10 in JUMP; retire_count=3 after 10 clocks.
- op_code=111111, and addi with ADDI_EN=0 -> ILLEGAL state, illegal_op pulse, no reg_write/mem_write, retire_count unchanged.
- reset asserted in MEM_READ mid-wait -> next cycle state=0, mem_read=1, iord=0, retire_count=0.
- CNT_W=2, 5 R-type instructions -> retire_count sequence 1,2,3,0,1.
